// File: rtl/clk_toggle_monitor.sv
// clk_toggle_monitor: counts rising edges of an asynchronous toggle signal
// over a fixed window of clk cycles and grades the count against a range.
module clk_toggle_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int WINDOW      = 1024,
  parameter int CNT_W       = 16,
  parameter int EXP_MIN     = 500,
  parameter int EXP_MAX     = 524
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             sig_i,
  output logic [CNT_W-1:0] meas_o,
  output logic             meas_valid_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             busy_o
);

  // ARM spans SYNC_STAGES+1 cycles (count 0..SYNC_STAGES); MEASURE spans WINDOW cycles.
  localparam int ARM_W = $clog2(SYNC_STAGES + 1);
  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(SYNC_STAGES);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, REPORT} state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic                   rise;
  logic [ARM_W-1:0]       arm_cnt;
  logic [WIN_W-1:0]       win_cnt;
  logic [CNT_W-1:0]       edge_cnt, edge_cnt_nxt;
  logic [31:0]            cnt_ext;
  logic                   in_range;
  logic                   win_done;

  // Synchronizer chain plus one edge-detect flop behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
      s_d    <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~s_d;

  // Saturating increment; the final window cycle's rise is folded in here too.
  assign edge_cnt_nxt = (rise && !(&edge_cnt)) ? edge_cnt + CNT_W'(1) : edge_cnt;

  // Range compare done wide so an EXP_MAX beyond the counter range still passes saturation.
  assign cnt_ext  = 32'(edge_cnt_nxt);
  assign in_range = (cnt_ext >= 32'(EXP_MIN)) && (cnt_ext <= 32'(EXP_MAX));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: dropping enable aborts ARM/MEASURE without a report.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = ARM;
      ARM:     if (!enable) state_nxt = IDLE;
               else if (arm_cnt == ARM_LAST) state_nxt = MEASURE;
      MEASURE: if (!enable) state_nxt = IDLE;
               else if (win_cnt == WIN_LAST) state_nxt = REPORT;
      REPORT:  state_nxt = enable ? MEASURE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign win_done = (state == MEASURE) && (state_nxt == REPORT);

  // Phase counters; everything outside MEASURE clears the window so REPORT edges are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm_cnt  <= '0;
      win_cnt  <= '0;
      edge_cnt <= '0;
    end else begin
      case (state)
        ARM: begin
          arm_cnt  <= arm_cnt + ARM_W'(1);
          win_cnt  <= '0;
          edge_cnt <= '0;
        end
        MEASURE: begin
          win_cnt  <= win_cnt + WIN_W'(1);
          edge_cnt <= edge_cnt_nxt;
        end
        default: begin
          arm_cnt  <= '0;
          win_cnt  <= '0;
          edge_cnt <= '0;
        end
      endcase
    end
  end

  // Result registers: updated only on a completed window, held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meas_o       <= '0;
      meas_valid_o <= 1'b0;
      pass_o       <= 1'b0;
      fail_o       <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      meas_valid_o <= win_done;
      busy_o       <= (state_nxt == ARM) || (state_nxt == MEASURE);
      if (win_done) begin
        meas_o <= edge_cnt_nxt;
        pass_o <= in_range;
        fail_o <= ~in_range;
      end
    end
  end

endmodule

// File: tb/tb_clk_toggle_monitor.sv
// Bench for clk_toggle_monitor: instance A grades a 16..16 range at CNT_W=16,
// instance B checks saturation at CNT_W=4.
module tb_clk_toggle_monitor;
  localparam int S     = 2;
  localparam int W     = 64;
  localparam int LAT   = S + 1 + W + 1;
  localparam int PER   = W + 1;
  localparam int A_MIN = 16, A_MAX = 16;
  localparam int B_MIN = 10, B_MAX = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, sig_a = 1'b0, en_b = 1'b0, sig_b = 1'b0;
  logic [15:0] meas_a;
  logic        vld_a, pass_a, fail_a, busy_a;
  logic [3:0]  meas_b;
  logic        vld_b, pass_b, fail_b, busy_b;

  int errors = 0, checks = 0, cyc = 0;
  int exp_q[$];
  bit prev_pass = 0, prev_fail = 0;
  int last_meas = 0, last_at = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  clk_toggle_monitor #(.SYNC_STAGES(S), .WINDOW(W), .CNT_W(16), .EXP_MIN(A_MIN), .EXP_MAX(A_MAX)) u_a (
    .clk(clk), .rst(rst), .enable(en_a), .sig_i(sig_a), .meas_o(meas_a),
    .meas_valid_o(vld_a), .pass_o(pass_a), .fail_o(fail_a), .busy_o(busy_a));

  clk_toggle_monitor #(.SYNC_STAGES(S), .WINDOW(W), .CNT_W(4), .EXP_MIN(B_MIN), .EXP_MAX(B_MAX)) u_b (
    .clk(clk), .rst(rst), .enable(en_b), .sig_i(sig_b), .meas_o(meas_b),
    .meas_valid_o(vld_b), .pass_o(pass_b), .fail_o(fail_b), .busy_o(busy_b));

  // n single-cycle-high pulses on sig_a, driven on negedges
  task automatic pulses_a(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); sig_a = 1'b1;
      @(negedge clk); sig_a = 1'b0;
    end
  endtask

  // bounded wait for the next result pulse on A; also notes whether pass/fail stayed put
  task automatic wait_pulse_a(input int bound, output bit seen, output bit held, output int at);
    seen = 0; held = 1; at = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      @(negedge clk);
      if (vld_a) begin seen = 1; at = cyc; end
      else if (pass_a !== prev_pass || fail_a !== prev_fail) held = 0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en_a = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (meas_a !== 16'd0) begin errors++; $display("FAIL reset_meas: got %0d expected 0", meas_a); end
    checks++; if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", vld_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b expected 0", pass_a); end
    checks++; if (fail_a !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b expected 0", fail_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    checks++; if ({meas_b, vld_b, pass_b, fail_b, busy_b} !== 8'd0) begin
      errors++; $display("FAIL reset_b: got %h expected 0", {meas_b, vld_b, pass_b, fail_b, busy_b});
    end
    en_a = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_idle_zero();
    bit seen, held; int at, c0, e; bit ep;
    en_a = 1'b1; sig_a = 1'b0; c0 = cyc;
    exp_q.push_back(0);
    wait_pulse_a(150, seen, held, at);
    checks++;
    if (!seen) begin errors++; $display("FAIL idle_zero_timeout: got no pulse expected pulse within 150"); end
    else begin
      e = exp_q.pop_front(); ep = (e >= A_MIN && e <= A_MAX);
      checks++; if (at - c0 !== LAT) begin errors++; $display("FAIL idle_zero_latency: got %0d expected %0d", at - c0, LAT); end
      checks++; if (meas_a !== 16'(e)) begin errors++; $display("FAIL idle_zero_meas: got %0d expected %0d", meas_a, e); end
      checks++; if ({pass_a, fail_a} !== {ep, !ep}) begin errors++; $display("FAIL idle_zero_grade: got %b%b expected %b%b", pass_a, fail_a, ep, !ep); end
      prev_pass = ep; prev_fail = !ep; last_meas = e; last_at = at;
    end
  endtask

  task automatic test_back_to_back();
    int ns[5] = '{16, 15, 16, 17, 16};
    bit seen, held; int at, e; bit ep;
    for (int i = 0; i < 5; i++) begin
      repeat (4) @(negedge clk);
      pulses_a(ns[i]);
      exp_q.push_back(ns[i]);
      wait_pulse_a(100, seen, held, at);
      checks++;
      if (!seen) begin errors++; $display("FAIL b2b_timeout[%0d]: got no pulse expected pulse", i); end
      else begin
        e = exp_q.pop_front(); ep = (e >= A_MIN && e <= A_MAX);
        checks++; if (at - last_at !== PER) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected %0d", i, at - last_at, PER); end
        checks++; if (meas_a !== 16'(e)) begin errors++; $display("FAIL b2b_meas[%0d]: got %0d expected %0d", i, meas_a, e); end
        checks++; if ({pass_a, fail_a} !== {ep, !ep}) begin errors++; $display("FAIL b2b_grade[%0d]: got %b%b expected %b%b", i, pass_a, fail_a, ep, !ep); end
        checks++; if (!held) begin errors++; $display("FAIL b2b_hold[%0d]: got changed expected held %b%b", i, prev_pass, prev_fail); end
        prev_pass = ep; prev_fail = !ep; last_meas = e; last_at = at;
      end
    end
  endtask

  task automatic test_abort();
    bit seen, held, got; int at, c0, e; bit ep;
    repeat (4) @(negedge clk);
    pulses_a(5);
    repeat (16) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b expected 1", busy_a); end
    en_a = 1'b0;
    @(negedge clk);
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b expected 0", busy_a); end
    got = 0;
    for (int k = 0; k < 100; k++) begin @(negedge clk); if (vld_a) got = 1; end
    checks++; if (got) begin errors++; $display("FAIL abort_no_pulse: got pulse expected none"); end
    checks++; if ({meas_a, pass_a, fail_a} !== {16'(last_meas), prev_pass, prev_fail}) begin
      errors++; $display("FAIL abort_held: got %0d/%b%b expected %0d/%b%b", meas_a, pass_a, fail_a, last_meas, prev_pass, prev_fail);
    end
    en_a = 1'b1; c0 = cyc;
    repeat (8) @(negedge clk);
    pulses_a(17);
    exp_q.push_back(17);
    wait_pulse_a(100, seen, held, at);
    checks++;
    if (!seen) begin errors++; $display("FAIL reenable_timeout: got no pulse expected pulse"); end
    else begin
      e = exp_q.pop_front(); ep = (e >= A_MIN && e <= A_MAX);
      checks++; if (at - c0 !== LAT) begin errors++; $display("FAIL reenable_latency: got %0d expected %0d", at - c0, LAT); end
      checks++; if (meas_a !== 16'(e)) begin errors++; $display("FAIL reenable_meas: got %0d expected %0d", meas_a, e); end
      checks++; if ({pass_a, fail_a} !== {ep, !ep}) begin errors++; $display("FAIL reenable_grade: got %b%b expected %b%b", pass_a, fail_a, ep, !ep); end
      prev_pass = ep; prev_fail = !ep; last_meas = e; last_at = at;
    end
  endtask

  task automatic test_reset_mid();
    bit seen, held; int at, c0, e; bit ep;
    repeat (20) @(negedge clk);
    checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b expected 1", busy_a); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({meas_a, vld_a, pass_a, fail_a, busy_a} !== 20'd0) begin
      errors++; $display("FAIL rstmid_async: got %0d/%b%b%b%b expected all 0", meas_a, vld_a, pass_a, fail_a, busy_a);
    end
    @(negedge clk); rst = 1'b0; c0 = cyc;
    prev_pass = 0; prev_fail = 0;
    exp_q.push_back(0);
    wait_pulse_a(150, seen, held, at);
    checks++;
    if (!seen) begin errors++; $display("FAIL rstmid_timeout: got no pulse expected pulse"); end
    else begin
      e = exp_q.pop_front(); ep = (e >= A_MIN && e <= A_MAX);
      checks++; if (at - c0 !== LAT) begin errors++; $display("FAIL rstmid_latency: got %0d expected %0d", at - c0, LAT); end
      checks++; if (meas_a !== 16'(e)) begin errors++; $display("FAIL rstmid_meas: got %0d expected %0d", meas_a, e); end
      checks++; if ({pass_a, fail_a} !== {ep, !ep}) begin errors++; $display("FAIL rstmid_grade: got %b%b expected %b%b", pass_a, fail_a, ep, !ep); end
      prev_pass = ep; prev_fail = !ep; last_meas = e; last_at = at;
    end
    en_a = 1'b0;
  endtask

  task automatic test_toggle_cont();
    int got, c0, e; bit ep;
    repeat (3) @(negedge clk);
    en_a = 1'b1; c0 = cyc; got = 0;
    repeat (3) exp_q.push_back(16);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (vld_a) begin
        e = exp_q.pop_front(); ep = (e >= A_MIN && e <= A_MAX);
        checks++; if (meas_a !== 16'(e)) begin errors++; $display("FAIL cont_meas[%0d]: got %0d expected %0d", got, meas_a, e); end
        checks++; if ({pass_a, fail_a} !== {ep, !ep}) begin errors++; $display("FAIL cont_grade[%0d]: got %b%b expected %b%b", got, pass_a, fail_a, ep, !ep); end
        checks++;
        if (got == 0) begin
          if (cyc - c0 !== LAT) begin errors++; $display("FAIL cont_latency: got %0d expected %0d", cyc - c0, LAT); end
        end else if (cyc - last_at !== PER) begin
          errors++; $display("FAIL cont_period[%0d]: got %0d expected %0d", got, cyc - last_at, PER);
        end
        last_at = cyc; got++;
        if (got == 3) begin en_a = 1'b0; break; end
      end
      if (k % 2 == 1) sig_a = ~sig_a;
    end
    checks++; if (got != 3) begin errors++; $display("FAIL cont_timeout: got %0d windows expected 3", got); end
    sig_a = 1'b0;
  endtask

  task automatic test_saturation();
    bit got; int e; bit ep;
    @(negedge clk); en_b = 1'b1; got = 0;
    exp_q.push_back(15);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (vld_b) begin
        got = 1;
        e = exp_q.pop_front(); ep = (e >= B_MIN && e <= B_MAX);
        checks++; if (meas_b !== 4'(e)) begin errors++; $display("FAIL sat_meas: got %0d expected %0d", meas_b, e); end
        checks++; if ({pass_b, fail_b} !== {ep, !ep}) begin errors++; $display("FAIL sat_grade: got %b%b expected %b%b", pass_b, fail_b, ep, !ep); end
        break;
      end
      sig_b = ~sig_b;
    end
    checks++; if (!got) begin errors++; $display("FAIL sat_timeout: got no pulse expected pulse"); end
    en_b = 1'b0; sig_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_toggle_cont();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1000000");
    $fatal(1);
  end

endmodule
